// File: rtl/counter_pkg.sv
// Shared types and constants for the sequential-counter library.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int CNT_W_DEF = 4;

endpackage

// File: rtl/down_counter_timer.sv
// Programmable down-counter/timer with one-cycle terminal-count pulse
// and optional auto-reload for periodic tick generation.
module down_counter_timer
    import counter_pkg::*;
#(
    parameter int WIDTH = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             busy
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] rld_q, rld_d;
    logic             tc_q, tc_d;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        rld_d   = rld_q;
        tc_d    = 1'b0;
        if (load) begin
            out_d   = load_val;
            rld_d   = load_val;
            state_d = (load_val != ZERO) ? RUN : DONE;
        end else begin
            case (state_q)
                RUN: begin
                    if (en) begin
                        // Terminal step: the count never shows 0 when reloading
                        if (out_q == ONE) begin
                            tc_d = 1'b1;
                            if (auto_reload) begin
                                out_d = rld_q;
                            end else begin
                                out_d   = ZERO;
                                state_d = DONE;
                            end
                        end else begin
                            out_d = out_q - ONE;
                        end
                    end
                end
                IDLE:    state_d = IDLE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= ZERO;
            rld_q   <= ZERO;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            rld_q   <= rld_d;
            tc_q    <= tc_d;
        end
    end

    assign out  = out_q;
    assign tc   = tc_q;
    assign busy = (state_q == RUN);

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: directed scenarios plus
// randomized traffic against a behavioural reference model.
module tb_down_counter_timer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         en = 1'b0;
    logic         auto_reload = 1'b0;
    logic [W-1:0] out;
    logic         tc;
    logic         busy;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: remaining count, reload value, running/done flags
    int m_out = 0;
    int m_rld = 0;
    bit m_run = 0;
    bit m_tc  = 0;

    down_counter_timer #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .load_val    (load_val),
        .en          (en),
        .auto_reload (auto_reload),
        .out         (out),
        .tc          (tc),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        if (rst) begin
            m_out = 0; m_rld = 0; m_run = 0; m_tc = 0;
        end else if (load) begin
            m_out = int'(load_val);
            m_rld = int'(load_val);
            m_run = (load_val != 0);
            m_tc  = 0;
        end else if (m_run && en && m_out == 1) begin
            m_tc = 1;
            if (auto_reload) m_out = m_rld;
            else begin
                m_out = 0;
                m_run = 0;
            end
        end else begin
            m_tc = 0;
            if (m_run && en) m_out = m_out - 1;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_load(input int v, input bit ar, input bit e);
        load = 1'b1; load_val = W'(v); auto_reload = ar; en = e;
        cyc();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        do_load(5, 0, 0);
        tests_run++;
        if (out !== 4'd5 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_preload: out=%0d busy=%b want out=5 busy=1", out, busy);
        end
        rst = 1'b1; en = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        tests_run++;
        if (out !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: out=%0d tc=%b busy=%b want 0 0 0", out, tc, busy);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            tests_run++;
            if (out !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL idle_en[%0d]: out=%0d tc=%b busy=%b want 0 0 0", i, out, tc, busy);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_one_shot();
        int exp_out [7] = '{4, 3, 2, 1, 0, 0, 0};
        bit exp_tc  [7] = '{0, 0, 0, 0, 1, 0, 0};
        bit exp_bsy [7] = '{1, 1, 1, 1, 0, 0, 0};
        do_load(4, 0, 1);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) cyc();
            tests_run++;
            if (out !== W'(exp_out[k]) || tc !== exp_tc[k] || busy !== exp_bsy[k]) begin
                tests_failed++;
                $display("FAIL one_shot[%0d]: out=%0d tc=%b busy=%b want %0d %0d %0d",
                         k, out, tc, busy, exp_out[k], exp_tc[k], exp_bsy[k]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_auto_reload();
        do_load(3, 1, 1);
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) cyc();
            tests_run++;
            if (out !== W'(3 - (k % 3)) || tc !== (k > 0 && k % 3 == 0) || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL auto_reload[%0d]: out=%0d tc=%b busy=%b want %0d %0d 1",
                         k, out, tc, busy, 3 - (k % 3), (k > 0 && k % 3 == 0));
            end
        end
        en = 1'b0; auto_reload = 1'b0;
    endtask

    task automatic test_enable_gating();
        bit en_seq  [4] = '{1, 0, 0, 1};
        int exp_out [4] = '{1, 1, 1, 0};
        bit exp_tc  [4] = '{0, 0, 0, 1};
        do_load(2, 0, 0);
        for (int k = 0; k < 4; k++) begin
            en = en_seq[k];
            cyc();
            tests_run++;
            if (out !== W'(exp_out[k]) || tc !== exp_tc[k]) begin
                tests_failed++;
                $display("FAIL en_gate[%0d]: out=%0d tc=%b want %0d %0d",
                         k, out, tc, exp_out[k], exp_tc[k]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_priority();
        do_load(2, 0, 1);
        cyc();
        tests_run++;
        if (out !== 4'd1) begin
            tests_failed++;
            $display("FAIL prio_setup: out=%0d want 1", out);
        end
        do_load(7, 0, 1);
        tests_run++;
        if (out !== 4'd7 || tc !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL prio_load: out=%0d tc=%b busy=%b want 7 0 1", out, tc, busy);
        end
        en = 1'b0;
        cyc();
        tests_run++;
        if (out !== 4'd7 || tc !== 1'b0) begin
            tests_failed++;
            $display("FAIL prio_hold: out=%0d tc=%b want 7 0", out, tc);
        end
    endtask

    task automatic test_zero_load();
        do_load(0, 1, 1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) cyc();
            tests_run++;
            if (out !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL zero_load[%0d]: out=%0d tc=%b busy=%b want 0 0 0", k, out, tc, busy);
            end
        end
        en = 1'b0; auto_reload = 1'b0;
    endtask

    task automatic test_max_period();
        int last_tc = 0;
        do_load(15, 1, 1);
        for (int k = 1; k <= 46; k++) begin
            cyc();
            if (tc === 1'b1) begin
                tests_run++;
                if (k - last_tc !== 15) begin
                    tests_failed++;
                    $display("FAIL max_period: tc gap=%0d at cycle %0d want 15", k - last_tc, k);
                end
                last_tc = k;
            end
            if (out === 4'd0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL max_zero: out=0 at cycle %0d want nonzero", k);
            end
        end
        tests_run++;
        if (last_tc !== 45) begin
            tests_failed++;
            $display("FAIL max_last_tc: last tc cycle=%0d want 45", last_tc);
        end
        en = 1'b0; auto_reload = 1'b0;
    endtask

    task automatic test_tc_then_load();
        do_load(1, 1, 1);
        cyc();
        load = 1'b1; load_val = 4'd6;
        tests_run++;
        if (tc !== 1'b1) begin
            tests_failed++;
            $display("FAIL tc_load_pre: tc=%b want 1", tc);
        end
        cyc();
        load = 1'b0;
        tests_run++;
        if (tc !== 1'b0 || out !== 4'd6) begin
            tests_failed++;
            $display("FAIL tc_load: tc=%b out=%0d want 0 6", tc, out);
        end
        en = 1'b0; auto_reload = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst         = ($urandom_range(0, 99) < 2);
            load        = ($urandom_range(0, 99) < 12);
            load_val    = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 1))
                                                      : W'($urandom_range(0, 15));
            en          = ($urandom_range(0, 99) < 75);
            auto_reload = $urandom_range(0, 1);
            cyc();
            tests_run++;
            if (out !== W'(m_out) || tc !== m_tc || busy !== m_run) begin
                tests_failed++;
                $display("FAIL random[%0d]: out=%0d tc=%b busy=%b want %0d %0d %0d",
                         i, out, tc, busy, m_out, m_tc, m_run);
            end
        end
        rst = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_enable_gating();
        test_priority();
        test_zero_load();
        test_max_period();
        test_tc_then_load();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
